// File: rtl/sig_stim_pkg.sv
// sig_stim_pkg: signature width, feedback taps, FSM states and one signature step.
package sig_stim_pkg;
    localparam int SIG_W = 16;
    localparam int SIG_TAPS [4] = '{6, 8, 11, 15};
    typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_DONE} state_t;
    function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0] q, input logic d);
        logic fb;
        fb = d;
        for (int i = 0; i < 4; i++) fb = fb ^ q[SIG_TAPS[i]];
        return {q[SIG_W-2:0], fb};
    endfunction
endpackage

// File: rtl/sig_stim_if.sv
// sig_stim_if: word stream in and probe lines out; slave is the transmitter side.
interface sig_stim_if;
    import sig_stim_pkg::*;
    logic [SIG_W-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             probe_clk;
    logic             probe_start;
    logic             probe_stop;
    logic             probe_data;
    modport master (output word_in, word_valid, input word_ready, probe_clk, probe_start, probe_stop, probe_data);
    modport slave  (input word_in, word_valid, output word_ready, probe_clk, probe_start, probe_stop, probe_data);
endinterface

// File: rtl/sig_stim_clkdiv.sv
// sig_stim_clkdiv: probe clock divider, DIV clks per half-period, rise/fall strobes, hold keeps the low phase.
module sig_stim_clkdiv #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_h,
    input  logic run,
    input  logic hold,
    output logic ph,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    logic          tick;
    assign tick = run && !hold && cnt == CW'(DIV - 1);
    assign rise = tick && !ph;
    assign fall = tick && ph;
    // Hold restarts the count so the low phase resumes at its full length.
    always_ff @(posedge clk or posedge reset_h)
        if (reset_h) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            cnt <= (!run || hold || tick) ? '0 : cnt + 1'b1;
            ph  <= run && (ph ^ tick);
        end
endmodule

// File: rtl/sig_stim.sv
// sig_stim: serializes 16-bit words MSB first into one gated probe window and accumulates the expected signature.
// SIG_STIM_FREERUN_EN: probe_clk free-runs between windows and START aligns to its next falling edge.
module sig_stim
    import sig_stim_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_h,
    input  logic             go,
    input  logic [LEN_W-1:0] len,
    sig_stim_if.slave        bus,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [SIG_W-1:0] expected
);
    state_t           state, state_nx;
    logic [LEN_W-1:0] rem;
    logic [SIG_W-1:0] sreg, pref;
    logic [4:0]       scnt;
    logic             pvalid, pend, data_q, rise, fall, div_run, go_acc, start_win, need, have, take, acc;

    sig_stim_clkdiv #(.DIV(DIV)) u_div (
        .clk, .reset_h, .run(div_run), .hold(stall), .ph(bus.probe_clk), .rise, .fall
    );

`ifdef SIG_STIM_FREERUN_EN
    assign div_run   = 1'b1;
    assign start_win = pend && fall;
`else
    assign div_run   = busy;
    assign start_win = go_acc;
`endif
    assign go_acc         = state == S_IDLE && go && !pend;
    assign need           = (fall && (state == S_START || state == S_BITS) && rem != '0) || stall;
    assign have           = scnt != '0 || pvalid;
    assign take           = need && have;
    assign acc            = bus.word_valid && bus.word_ready;
    assign bus.probe_data = data_q;

    always_ff @(posedge clk or posedge reset_h)
        if (reset_h) state <= S_IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == S_IDLE ? (start_win ? S_START : S_IDLE) :
                   state == S_DONE ? S_IDLE :
                   !fall           ? state :
                   state == S_STOP ? S_DONE :
                   rem != '0       ? S_BITS : S_STOP;

    // Prefetch only while the window still needs bits beyond the current shift word.
    always_comb begin
        busy            = pend || (state != S_IDLE && state != S_DONE);
        done            = state == S_DONE;
        bus.probe_start = state == S_START;
        bus.probe_stop  = state == S_STOP;
        bus.word_ready  = busy && !pvalid && 32'(rem) > 32'(scnt);
    end

    always_ff @(posedge clk or posedge reset_h)
        if (reset_h) begin
            rem      <= '0;
            sreg     <= '0;
            pref     <= '0;
            scnt     <= '0;
            pvalid   <= 1'b0;
            pend     <= 1'b0;
            data_q   <= 1'b0;
            stall    <= 1'b0;
            expected <= '0;
        end else begin
            pend     <= start_win ? 1'b0 : go_acc ? 1'b1 : pend;
            rem      <= go_acc ? len : take ? rem - 1'b1 : rem;
            scnt     <= go_acc ? '0 : !take ? scnt : scnt != '0 ? scnt - 1'b1 : 5'd15;
            sreg     <= !take ? sreg : scnt != '0 ? sreg << 1 : pref << 1;
            data_q   <= take ? (scnt != '0 ? sreg[SIG_W-1] : pref[SIG_W-1]) : fall ? 1'b0 : data_q;
            pvalid   <= acc || (pvalid && !(take && scnt == '0));
            pref     <= acc ? bus.word_in : pref;
            stall    <= need && !have;
            expected <= go_acc ? '0 : (rise && state == S_BITS) ? sig_next(expected, data_q) : expected;
        end
endmodule

// File: tb/tb_sig_stim.sv
// tb_sig_stim: random word windows checked against a bit-stream signature model and an in-bench probe analyzer.
module tb_sig_stim;
    localparam int DIV = 4;
    logic        clk = 1'b0, reset_h = 1'b1, go = 1'b0;
    logic [15:0] len = '0;
    logic        busy, done, stall;
    logic [15:0] expected;
    sig_stim_if bus ();
    sig_stim #(.DIV(DIV), .LEN_W(16)) dut (
        .clk, .reset_h, .go, .len, .bus(bus.slave), .busy, .done, .stall, .expected
    );
    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signature of the first n bits of the word stream, MSB first.
    function automatic logic [15:0] ref_sig(input int n, input logic [15:0] w[$]);
        logic [15:0] q, wd;
        logic        d;
        q = '0;
        for (int k = 0; k < n; k++) begin
            wd = w[k / 16];
            d  = wd[15 - k % 16];
            q  = {q[14:0], d ^ q[6] ^ q[8] ^ q[11] ^ q[15]};
        end
        return q;
    endfunction

    logic [15:0] wq[$], src_q[$];
    int          gq[$], gap_q[$];
    logic        run_src = 1'b0, fire = 1'b0;
    int          taken = 0, gap_cnt = 0;
    initial begin
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        forever begin
            @(negedge clk);
            if (fire) begin
                taken++;
                bus.word_valid = 1'b0;
            end
            if (!run_src) begin
                bus.word_valid = 1'b0;
                gap_cnt        = 0;
                taken          = 0;
            end else if (!bus.word_valid && src_q.size() != 0) begin
                if (gap_cnt < gap_q[0]) gap_cnt++;
                else begin
                    bus.word_in    = src_q.pop_front();
                    void'(gap_q.pop_front());
                    gap_cnt        = 0;
                    bus.word_valid = 1'b1;
                end
            end
            fire = bus.word_valid && bus.word_ready;
        end
    end

    logic        mon_clr = 1'b1, pclk_d = 1'b0, armed = 1'b0, stall_seen = 1'b0, stall_bad = 1'b0;
    logic [15:0] ana_sig = '0;
    int          rises = 0, ana_bits = 0, done_cnt = 0, stops = 0;
    initial forever begin
        @(negedge clk);
        if (mon_clr) begin
            rises = 0; ana_bits = 0; done_cnt = 0; stops = 0;
            armed = 1'b0; ana_sig = '0; stall_seen = 1'b0; stall_bad = 1'b0;
        end else begin
            if (stall) begin
                stall_seen = 1'b1;
                if (bus.probe_clk) stall_bad = 1'b1;
            end
            if (done) done_cnt++;
            if (bus.probe_clk && !pclk_d) begin
                rises++;
                if (bus.probe_start) begin
                    armed = 1'b1; ana_sig = '0; ana_bits = 0;
                end else if (bus.probe_stop) begin
                    armed = 1'b0; stops++;
                end else if (armed) begin
                    ana_sig = {ana_sig[14:0], bus.probe_data ^ ana_sig[6] ^ ana_sig[8] ^ ana_sig[11] ^ ana_sig[15]};
                    ana_bits++;
                end
            end
        end
        pclk_d = bus.probe_clk;
    end

    task automatic fill(input int cnt, input int maxgap);
        wq.delete();
        gq.delete();
        for (int i = 0; i < cnt; i++) begin
            wq.push_back(16'($urandom));
            gq.push_back(int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic arm(input int n);
        run_src = 1'b0;
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        src_q   = wq;
        gap_q   = gq;
        run_src = 1'b1;
        mon_clr = 1'b0;
        len     = 16'(n);
        go      = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run_win(input int n, input string tag);
        logic [15:0] model;
        logic        got_done, busy_at_done;
        int          budget;
        model        = ref_sig(n, wq);
        budget       = (n + 3) * 2 * DIV + gq.sum() + 200;
        got_done     = 1'b0;
        busy_at_done = 1'b1;
        arm(n);
        for (int c = 0; c < budget && !got_done; c++) begin
            @(negedge clk);
            got_done     = done;
            busy_at_done = busy;
        end
        check({tag, ".done"}, got_done, 1);
        check({tag, ".busy_at_done"}, busy_at_done, 0);
        check({tag, ".exp"}, expected, model);
        @(negedge clk);
        check({tag, ".pulse"}, {done, busy}, 0);
        check({tag, ".done_cnt"}, done_cnt, 1);
        check({tag, ".words"}, taken, (n + 15) / 16);
        check({tag, ".cycles"}, rises, n + 2);
        check({tag, ".stops"}, stops, 1);
        check({tag, ".nbits"}, ana_bits, n);
        check({tag, ".sigan"}, ana_sig, model);
        check({tag, ".stall_clk"}, stall_bad, 0);
        repeat (3) @(negedge clk);
        check({tag, ".hold"}, expected, model);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.out", {busy, done, stall, bus.probe_clk, bus.probe_start, bus.probe_stop, bus.probe_data, bus.word_ready}, 0);
        check("rst.exp", expected, 0);
        reset_h = 1'b0;
        @(negedge clk);
        fill(1, 0);
        run_win(0, "len0");
        check("len0.sig", expected, 0);
        wq = '{16'h8000, 16'h1234};
        gq = '{0, 0};
        run_win(1, "len1");
        check("len1.sig", expected, 16'h0001);
        wq = '{16'h0000, 16'h0000, 16'hffff};
        gq = '{0, 0, 0};
        run_win(32, "len32");
        check("len32.sig", expected, 0);
        fill(4, 0);
        gq[2] = 300;
        run_win(40, "stall");
        check("stall.seen", stall_seen, 1);
        fill(8, 3);
        run_win(100, "len100");
        fill(5, 0);
        arm(60);
        for (int c = 0; c < 400 && rises < 5; c++) @(negedge clk);
        check("mrst.reached", rises >= 5, 1);
        reset_h = 1'b1;
        #1;
        check("mrst.out", {busy, done, stall, bus.probe_clk, bus.probe_start, bus.probe_stop, bus.probe_data, bus.word_ready}, 0);
        check("mrst.exp", expected, 0);
        @(negedge clk);
        reset_h = 1'b0;
        fill(4, 5);
        run_win(33, "post_rst");
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(0, 70));
            fill((n + 15) / 16 + 1, 40);
            run_win(n, $sformatf("rnd%0d", t));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
